// File: rtl/mem_responder_pkg.sv
// Shared definitions for mem_responder: state encoding, default widths and a log2 helper.
// Defining RV64I selects the 64-bit default word width.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_ACK  = 2'b10
  } state_e;

`ifdef RV64I
  localparam int DEFAULT_DATA_SIZE = 64;
`else
  localparam int DEFAULT_DATA_SIZE = 32;
`endif
  localparam int DEFAULT_BYTE_NUM = DEFAULT_DATA_SIZE / 8;

  // Smallest n with 2**n >= value; drives the byte-offset shift and index widths.
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mem_responder_byte_ram_array.sv
// byte_ram_array: synchronous single-port word array with per-lane write enables
// and a registered read port that holds its value between reads.
module byte_ram_array
  import mem_responder_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int BYTE_NUM  = DATA_SIZE / 8,
  parameter int DEPTH     = 1024,
  parameter int IDX_W     = log2_ceil(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 wr,
  input  logic [BYTE_NUM-1:0]  lane_we,
  input  logic [IDX_W-1:0]     index,
  input  logic [DATA_SIZE-1:0] write_data,
  output logic [DATA_SIZE-1:0] read_data
);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [DATA_SIZE-1:0] read_data_d, read_data_q;

  // Contents are never reset; a write landing while reset is held is dropped.
  always_ff @(posedge clock) begin
    if (en && wr && !reset) begin
      for (int i = 0; i < BYTE_NUM; i++) begin
        if (lane_we[i]) mem[index][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    read_data_d = read_data_q;
    if (en && !wr) read_data_d = mem[index];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) read_data_q <= '0;
    else       read_data_q <= read_data_d;
  end

  assign read_data = read_data_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: captures a read/write request, waits BUSY_CYCLES, performs the access and pulses ack.
// Define MEM_ERR_EN to add the mem_err port and capture-time request checking.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int  DATA_SIZE   = DEFAULT_DATA_SIZE,
  parameter int  ADDR_SIZE   = 32,
  parameter int  DEPTH       = 1024,
  parameter int  BUSY_CYCLES = 2,
  localparam int BYTE_NUM    = DATA_SIZE / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [BYTE_NUM-1:0]  byte_en,
  input  logic [ADDR_SIZE-1:0] address,
  input  logic [DATA_SIZE-1:0] write_data,
  output logic [DATA_SIZE-1:0] read_data,
`ifdef MEM_ERR_EN
  output logic                 mem_err,
`endif
  output logic                 ack
);

  localparam int OFFSET_W = log2_ceil(BYTE_NUM);
  localparam int WORD_W   = ADDR_SIZE - OFFSET_W;
  localparam int IDX_W    = (DEPTH > 1) ? log2_ceil(DEPTH) : 1;
  localparam int CNT_W    = (BUSY_CYCLES > 1) ? log2_ceil(BUSY_CYCLES) : 1;
  localparam int CNT_INIT = (BUSY_CYCLES > 0) ? BUSY_CYCLES - 1 : 0;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [BYTE_NUM-1:0]  be_q, be_d;
  logic                 wr_q, wr_d;
  logic                 err_q, err_d;

  logic                 req;
  logic                 capture_err;
  logic [WORD_W-1:0]    cap_word;

  logic                 acc_go, acc_wr, acc_err, ram_en;
  logic [WORD_W-1:0]    acc_word;
  logic [BYTE_NUM-1:0]  acc_be;
  logic [DATA_SIZE-1:0] acc_wdata;
  logic [IDX_W-1:0]     acc_index;

  assign req      = rd_en | wr_en;
  assign cap_word = address[ADDR_SIZE-1:OFFSET_W];

`ifdef MEM_ERR_EN
  localparam logic [WORD_W:0] DEPTH_EXT = (WORD_W + 1)'(DEPTH);
  int lane_count;

  always_comb begin
    lane_count = 0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      if (byte_en[i]) lane_count++;
    end
    capture_err = ({1'b0, cap_word} >= DEPTH_EXT)
               || (rd_en && wr_en)
               || (int'(address[OFFSET_W-1:0]) + lane_count > BYTE_NUM);
  end
`else
  logic unused_offset;
  assign unused_offset = ^address[OFFSET_W-1:0];
  assign capture_err   = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Busy ignores the enables entirely, so a dropped request still completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          word_d  = cap_word;
          wdata_d = write_data;
          be_d    = byte_en;
          wr_d    = wr_en;
          err_d   = capture_err;
          cnt_d   = CNT_W'(CNT_INIT);
          state_d = (BUSY_CYCLES == 0) ? S_ACK : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The array access fires on the edge into Ack; with no busy cycles that is the
  // capture edge itself, so the live request fields feed the array directly.
  always_comb begin
    ack       = (state_q == S_ACK);
    acc_go    = 1'b0;
    acc_word  = word_q;
    acc_wr    = wr_q;
    acc_be    = be_q;
    acc_wdata = wdata_q;
    acc_err   = err_q;
    if (state_q == S_IDLE && req && BUSY_CYCLES == 0) begin
      acc_go    = 1'b1;
      acc_word  = cap_word;
      acc_wr    = wr_en;
      acc_be    = byte_en;
      acc_wdata = write_data;
      acc_err   = capture_err;
    end else if (state_q == S_BUSY && cnt_q == '0) begin
      acc_go = 1'b1;
    end
  end

`ifdef MEM_ERR_EN
  assign mem_err = ack && err_q;
`endif

  assign ram_en    = acc_go && !acc_err;
  assign acc_index = IDX_W'(acc_word % WORD_W'(DEPTH));

  byte_ram_array #(
    .DATA_SIZE (DATA_SIZE),
    .BYTE_NUM  (BYTE_NUM),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clock      (clock),
    .reset      (reset),
    .en         (ram_en),
    .wr         (acc_wr),
    .lane_we    (acc_be),
    .index      (acc_index),
    .write_data (acc_wdata),
    .read_data  (read_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two busy cycles, one with none.
// With MEM_ERR_EN defined the error port is connected and checked instead of address wrap.
module tb_mem_responder;

  logic        clock, reset;
  logic        rd_en2, wr_en2, rd_en0, wr_en0;
  logic [3:0]  byte_en2, byte_en0;
  logic [31:0] address2, address0, write_data2, write_data0;
  logic [31:0] read_data2, read_data0;
  logic        ack2, ack0;
  logic        mem_err2, mem_err0;
  int          checks, errors;

  mem_responder #(.DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH(1024), .BUSY_CYCLES(2)) u_dut2 (
    .clock      (clock),
    .reset      (reset),
    .rd_en      (rd_en2),
    .wr_en      (wr_en2),
    .byte_en    (byte_en2),
    .address    (address2),
    .write_data (write_data2),
    .read_data  (read_data2),
`ifdef MEM_ERR_EN
    .mem_err    (mem_err2),
`endif
    .ack        (ack2)
  );

  mem_responder #(.DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH(1024), .BUSY_CYCLES(0)) u_dut0 (
    .clock      (clock),
    .reset      (reset),
    .rd_en      (rd_en0),
    .wr_en      (wr_en0),
    .byte_en    (byte_en0),
    .address    (address0),
    .write_data (write_data0),
    .read_data  (read_data0),
`ifdef MEM_ERR_EN
    .mem_err    (mem_err0),
`endif
    .ack        (ack0)
  );

`ifndef MEM_ERR_EN
  assign mem_err2 = 1'b0;
  assign mem_err0 = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Presents one request before a rising edge and counts edges until ack is seen.
  // The capture edge is edge 1, so ack arrives after edge BUSY_CYCLES+1.
  task automatic txn(input bit use0, input bit rd, input bit wr,
                     input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                     output int edges, output logic [31:0] rdata, output logic err,
                     output logic ack_after);
    bit got;
    @(negedge clock);
    if (use0) begin
      rd_en0 = rd; wr_en0 = wr; address0 = addr; write_data0 = data; byte_en0 = be;
    end else begin
      rd_en2 = rd; wr_en2 = wr; address2 = addr; write_data2 = data; byte_en2 = be;
    end
    edges = 0;
    got   = 1'b0;
    rdata = 'x;
    err   = 1'b0;
    while (!got && edges < 12) begin
      @(posedge clock); #1;
      edges++;
      if ((use0 ? ack0 : ack2) === 1'b1) begin
        got   = 1'b1;
        rdata = use0 ? read_data0 : read_data2;
        err   = use0 ? mem_err0 : mem_err2;
      end
    end
    if (use0) begin rd_en0 = 1'b0; wr_en0 = 1'b0; end
    else      begin rd_en2 = 1'b0; wr_en2 = 1'b0; end
    if (!got) edges = -1;
    @(posedge clock); #1;
    ack_after = use0 ? ack0 : ack2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (ack2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack2: got %b expected 0", ack2); end
    checks++; if (read_data2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata2: got %h expected 00000000", read_data2); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack0: got %b expected 0", ack0); end
    checks++; if (read_data0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata0: got %h expected 00000000", read_data0); end
`ifdef MEM_ERR_EN
    checks++; if (mem_err2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_err: got %b expected 0", mem_err2); end
`endif
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (ack2 !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_ack2: got %b expected 0", ack2); end
  endtask

  task automatic test_read_latency();
    int e; logic [31:0] rd; logic er, aa;
    txn(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, e, rd, er, aa);
    checks++; if (e !== 3) begin errors++; $display("[TB] FAIL write_latency: got %0d edges expected 3", e); end
    txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, e, rd, er, aa);
    checks++; if (e !== 3) begin errors++; $display("[TB] FAIL read_latency: got %0d edges expected 3", e); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data: got %h expected deadbeef", rd); end
    checks++; if (aa !== 1'b0) begin errors++; $display("[TB] FAIL ack_single: got %b expected 0", aa); end
  endtask

  task automatic test_byte_lanes();
    int e; logic [31:0] rd; logic er, aa;
    txn(1'b0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, e, rd, er, aa);
    txn(1'b0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h3, e, rd, er, aa);
    txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, e, rd, er, aa);
    checks++; if (rd !== 32'h1122CCDD) begin errors++; $display("[TB] FAIL lanes_low_half: got %h expected 1122ccdd", rd); end
    txn(1'b0, 1'b0, 1'b1, 32'h24, 32'h00000000, 4'hF, e, rd, er, aa);
    checks++; if (read_data2 !== 32'h1122CCDD) begin errors++; $display("[TB] FAIL rdata_hold_on_write: got %h expected 1122ccdd", read_data2); end
    txn(1'b0, 1'b0, 1'b1, 32'h20, 32'h99000000, 4'h8, e, rd, er, aa);
    txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, e, rd, er, aa);
    checks++; if (rd !== 32'h9922CCDD) begin errors++; $display("[TB] FAIL lanes_top_byte: got %h expected 9922ccdd", rd); end
  endtask

  task automatic test_back_to_back();
    int e, n, gap; bit got; logic [31:0] rd; logic er, aa;
    txn(1'b1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, e, rd, er, aa);
    checks++; if (e !== 1) begin errors++; $display("[TB] FAIL zero_busy_latency: got %0d edges expected 1", e); end
    txn(1'b1, 1'b0, 1'b1, 32'h44, 32'h01020304, 4'hF, e, rd, er, aa);
    @(negedge clock);
    rd_en0 = 1'b1; address0 = 32'h40; byte_en0 = 4'hF;
    n = 0; got = 1'b0;
    while (!got && n < 8) begin
      @(posedge clock); #1; n++;
      if (ack0 === 1'b1) got = 1'b1;
    end
    checks++; if (read_data0 !== 32'hCAFEF00D || !got) begin errors++; $display("[TB] FAIL fetch_data: got %h expected cafef00d", read_data0); end
    rd_en0 = 1'b0;
    @(posedge clock); #1;
    rd_en0 = 1'b1; address0 = 32'h44;
    gap = 0; got = 1'b0;
    while (!got && gap < 8) begin
      @(posedge clock); #1; gap++;
      if (ack0 === 1'b1) got = 1'b1;
    end
    checks++; if (!got || gap + 1 !== 2) begin errors++; $display("[TB] FAIL ack_spacing: got %0d edges expected 2", gap + 1); end
    checks++; if (read_data0 !== 32'h01020304) begin errors++; $display("[TB] FAIL load_data: got %h expected 01020304", read_data0); end
    rd_en0 = 1'b0;
    @(posedge clock); #1;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ack_low: got %b expected 0", ack0); end
  endtask

  task automatic test_reset_in_busy();
    int e; bit seen; logic [31:0] rd; logic er, aa;
    txn(1'b0, 1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF, e, rd, er, aa);
    @(negedge clock);
    wr_en2 = 1'b1; address2 = 32'h30; write_data2 = 32'hFFFFFFFF; byte_en2 = 4'hF;
    @(posedge clock); #1;
    @(negedge clock);
    reset = 1'b1; wr_en2 = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(posedge clock); #1; if (ack2 === 1'b1) seen = 1'b1; end
    checks++; if (read_data2 !== 32'h0) begin errors++; $display("[TB] FAIL busy_reset_rdata: got %h expected 00000000", read_data2); end
    @(negedge clock);
    reset = 1'b0;
    repeat (4) begin @(posedge clock); #1; if (ack2 === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL busy_reset_no_ack: got %b expected 0", seen); end
    txn(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, e, rd, er, aa);
    checks++; if (e !== 3) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d edges expected 3", e); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("[TB] FAIL busy_reset_word: got %h expected 12345678", rd); end
  endtask

  task automatic test_rd_drop();
    int n, extra; bit got;
    @(negedge clock);
    rd_en2 = 1'b1; address2 = 32'h10; byte_en2 = 4'hF;
    @(posedge clock); #1;
    rd_en2 = 1'b0;
    n = 1; got = 1'b0;
    while (!got && n < 12) begin
      @(posedge clock); #1; n++;
      if (ack2 === 1'b1) got = 1'b1;
    end
    checks++; if (n !== 3 || !got) begin errors++; $display("[TB] FAIL drop_latency: got %0d edges expected 3", n); end
    checks++; if (read_data2 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL drop_data: got %h expected deadbeef", read_data2); end
    extra = 0;
    repeat (8) begin @(posedge clock); #1; if (ack2 === 1'b1) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL drop_extra_ack: got %0d expected 0", extra); end
  endtask

  task automatic test_addr_edge();
    int e; logic [31:0] rd; logic er, aa;
    txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0BADCAFE, 4'hF, e, rd, er, aa);
    txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, e, rd, er, aa);
`ifdef MEM_ERR_EN
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL good_read_err: got %b expected 0", er); end
    txn(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, e, rd, er, aa);
    checks++; if (e !== 3) begin errors++; $display("[TB] FAIL oob_latency: got %0d edges expected 3", e); end
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL oob_mem_err: got %b expected 1", er); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL oob_rdata_kept: got %h expected deadbeef", rd); end
    txn(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 4'h3, e, rd, er, aa);
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL half_fit_err: got %b expected 0", er); end
    txn(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 4'h3, e, rd, er, aa);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_err: got %b expected 1", er); end
    txn(1'b0, 1'b1, 1'b1, 32'h50, 32'h5A5A5A5A, 4'hF, e, rd, er, aa);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL both_en_err: got %b expected 1", er); end
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, e, rd, er, aa);
    checks++; if (rd !== 32'h0BADCAFE) begin errors++; $display("[TB] FAIL word0_intact: got %h expected 0badcafe", rd); end
`else
    txn(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, e, rd, er, aa);
    checks++; if (e !== 3) begin errors++; $display("[TB] FAIL wrap_latency: got %0d edges expected 3", e); end
    checks++; if (rd !== 32'h0BADCAFE) begin errors++; $display("[TB] FAIL wrap_data: got %h expected 0badcafe", rd); end
    txn(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 4'hF, e, rd, er, aa);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL low_bits_ignored: got %h expected deadbeef", rd); end
    txn(1'b0, 1'b1, 1'b1, 32'h50, 32'h5A5A5A5A, 4'hF, e, rd, er, aa);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL both_en_rdata: got %h expected deadbeef", rd); end
    txn(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 4'hF, e, rd, er, aa);
    checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL write_wins: got %h expected 5a5a5a5a", rd); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    rd_en2 = 1'b0; wr_en2 = 1'b0; byte_en2 = 4'h0; address2 = '0; write_data2 = '0;
    rd_en0 = 1'b0; wr_en0 = 1'b0; byte_en0 = 4'h0; address0 = '0; write_data0 = '0;
    $display("[TB] starting mem_responder bench");
    test_reset();
    test_read_latency();
    test_byte_lanes();
    test_back_to_back();
    test_reset_in_busy();
    test_rd_drop();
    test_addr_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
